// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline stage register with a valid/ready handshake, a skid entry that
// absorbs one bundle during EX stalls, squash on flush, and a saturating bubble counter.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 8,
    parameter int WB_W   = 2,
    parameter int M_W    = 3,
    parameter int EX_W   = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   in_wb,
    input  logic [M_W-1:0]    in_m,
    input  logic [EX_W-1:0]   in_ex,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_reg1,
    input  logic [DATA_W-1:0] in_reg2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [5:0]        in_funct,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   out_wb,
    output logic [M_W-1:0]    out_m,
    output logic [EX_W-1:0]   out_ex,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic [DATA_W-1:0] out_reg1,
    output logic [DATA_W-1:0] out_reg2,
    output logic [DATA_W-1:0] out_imm,
    output logic [5:0]        out_funct,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [M_W-1:0]    m;
        logic [EX_W-1:0]   ex;
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] reg1;
        logic [DATA_W-1:0] reg2;
        logic [DATA_W-1:0] imm;
        logic [5:0]        funct;
        logic [4:0]        rt;
        logic [4:0]        rd;
    } bundle_t;

    bundle_t in_bundle;
    bundle_t main_reg;
    bundle_t main_next;
    bundle_t skid_reg;
    bundle_t skid_next;

    logic main_valid_reg;
    logic main_valid_next;
    logic skid_valid_reg;
    logic skid_valid_next;

    logic [CNT_W-1:0] bubble_cnt_reg;
    logic [CNT_W-1:0] bubble_cnt_next;

    logic in_fire;
    logic out_fire;
    logic main_open;

    always_comb begin
        in_bundle.wb    = in_wb;
        in_bundle.m     = in_m;
        in_bundle.ex    = in_ex;
        in_bundle.pc    = in_pc;
        in_bundle.instr = in_instr;
        in_bundle.reg1  = in_reg1;
        in_bundle.reg2  = in_reg2;
        in_bundle.imm   = in_imm;
        in_bundle.funct = in_funct;
        in_bundle.rt    = in_rt;
        in_bundle.rd    = in_rd;
    end

    // in_ready comes only from the skid valid flop, so there is no path from out_ready.
    assign in_ready  = ~skid_valid_reg;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_valid_reg & out_ready;
    assign main_open = ~main_valid_reg | out_fire;

    always_comb begin
        main_next       = main_reg;
        skid_next       = skid_reg;
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;

        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (main_open) begin
            if (skid_valid_reg) begin
                main_next       = skid_reg;
                main_valid_next = 1'b1;
                skid_valid_next = 1'b0;
                if (in_fire) begin
                    skid_next       = in_bundle;
                    skid_valid_next = 1'b1;
                end
            end else if (in_fire) begin
                main_next       = in_bundle;
                main_valid_next = 1'b1;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (in_fire) begin
            skid_next       = in_bundle;
            skid_valid_next = 1'b1;
        end
    end

    // Counts every cycle the execute stage sees no valid bundle, sticking at all-ones.
    always_comb begin
        bubble_cnt_next = bubble_cnt_reg;
        if (!main_valid_reg && (bubble_cnt_reg != {CNT_W{1'b1}})) begin
            bubble_cnt_next = bubble_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            bubble_cnt_reg <= '0;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            bubble_cnt_reg <= bubble_cnt_next;
        end
    end

    assign out_valid  = main_valid_reg;
    assign out_pc     = main_reg.pc;
    assign out_instr  = main_reg.instr;
    assign out_reg1   = main_reg.reg1;
    assign out_reg2   = main_reg.reg2;
    assign out_imm    = main_reg.imm;
    assign out_funct  = main_reg.funct;
    assign out_rt     = main_reg.rt;
    assign out_rd     = main_reg.rd;
    assign bubble_cnt = bubble_cnt_reg;

    // Control groups read as a bubble (all zero) whenever the main entry is empty.
    genvar gi;
    generate
        for (gi = 0; gi < WB_W; gi++) begin : g_wb_gate
            assign out_wb[gi] = main_reg.wb[gi] & main_valid_reg;
        end
        for (gi = 0; gi < M_W; gi++) begin : g_m_gate
            assign out_m[gi] = main_reg.m[gi] & main_valid_reg;
        end
        for (gi = 0; gi < EX_W; gi++) begin : g_ex_gate
            assign out_ex[gi] = main_reg.ex[gi] & main_valid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: a driver pushes expected bundles into a queue,
// and a monitor pops and compares them whenever the DUT hands a bundle to execute.
module tb_id_ex_pipe_reg;

    localparam int DATA_W = 32;
    localparam int PC_W   = 8;
    localparam int WB_W   = 2;
    localparam int M_W    = 3;
    localparam int EX_W   = 3;
    localparam int CNT_W  = 4;
    localparam int BW     = WB_W + M_W + EX_W + PC_W + 4 * DATA_W + 6 + 5 + 5;

    logic              clk = 1'b0;
    logic              rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [WB_W-1:0]   in_wb, out_wb;
    logic [M_W-1:0]    in_m, out_m;
    logic [EX_W-1:0]   in_ex, out_ex;
    logic [PC_W-1:0]   in_pc, out_pc;
    logic [DATA_W-1:0] in_instr, in_reg1, in_reg2, in_imm;
    logic [DATA_W-1:0] out_instr, out_reg1, out_reg2, out_imm;
    logic [5:0]        in_funct, out_funct;
    logic [4:0]        in_rt, in_rd, out_rt, out_rd;
    logic [CNT_W-1:0]  bubble_cnt;

    int compared   = 0;
    int mismatched = 0;
    logic [BW-1:0] exp_q[$];

    always #5 clk = ~clk;

    id_ex_pipe_reg #(
        .DATA_W(DATA_W), .PC_W(PC_W), .WB_W(WB_W), .M_W(M_W), .EX_W(EX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wb(in_wb), .in_m(in_m), .in_ex(in_ex), .in_pc(in_pc),
        .in_instr(in_instr), .in_reg1(in_reg1), .in_reg2(in_reg2), .in_imm(in_imm),
        .in_funct(in_funct), .in_rt(in_rt), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wb(out_wb), .out_m(out_m), .out_ex(out_ex), .out_pc(out_pc),
        .out_instr(out_instr), .out_reg1(out_reg1), .out_reg2(out_reg2), .out_imm(out_imm),
        .out_funct(out_funct), .out_rt(out_rt), .out_rd(out_rd),
        .bubble_cnt(bubble_cnt)
    );

    // Every field of a test bundle is a fixed function of its PC.
    function automatic logic [BW-1:0] mk(input logic [PC_W-1:0] pc);
        logic [DATA_W-1:0] r1;
        r1 = {pc, pc, pc, pc};
        return {pc[3:2], pc[4:2], pc[5:3] ^ 3'b101, pc, 32'h0100_0000 | {24'h0, pc},
                r1, ~r1, {{24{pc[7]}}, pc}, pc[5:0] ^ 6'h2A, pc[6:2], ~pc[6:2]};
    endfunction

    function automatic logic [BW-1:0] actual();
        return {out_wb, out_m, out_ex, out_pc, out_instr, out_reg1, out_reg2, out_imm,
                out_funct, out_rt, out_rd};
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [PC_W-1:0] pc);
        {in_wb, in_m, in_ex, in_pc, in_instr, in_reg1, in_reg2, in_imm,
         in_funct, in_rt, in_rd} = mk(pc);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a bundle until it is accepted (bounded), pushing its expectation on acceptance.
    task automatic send(input logic [PC_W-1:0] pc);
        bit done = 0;
        apply(pc);
        in_valid = 1'b1;
        for (int n = 0; n < 10 && !done; n++) begin
            if (in_ready) begin
                exp_q.push_back(mk(pc));
                done = 1;
            end
            cyc();
        end
        if (!done) chk("send_timeout", BW'(0), BW'(pc));
        $display("send pc=%h accepted=%0d", pc, done);
    endtask

    always @(negedge clk) begin
        logic [BW-1:0] e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", actual(), BW'(0));
            end else begin
                e = exp_q.pop_front();
                chk("bundle", actual(), e);
                $display("out pc=%h", out_pc);
            end
        end else if (!out_valid) begin
            chk("ctrl_gated", BW'({out_wb, out_m, out_ex}), BW'(0));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        apply(8'hFC);
        in_wb = 2'b11;
        cyc();
        cyc();
        chk("rst_out_valid", BW'(out_valid), BW'(0));
        chk("rst_out_wb", BW'(out_wb), BW'(0));
        chk("rst_bubble", BW'(bubble_cnt), BW'(0));
        chk("rst_in_ready", BW'(in_ready), BW'(1));

        rst_n = 1'b1;
        send(8'h04);
        chk("lat_valid", BW'(out_valid), BW'(1));
        chk("lat_pc", BW'(out_pc), BW'(8'h04));
        chk("lat_bubble", BW'(bubble_cnt), BW'(1));

        for (int i = 0; i < 4; i++) begin
            send(PC_W'(4 * i));
            chk("stream_pc", BW'(out_pc), BW'(4 * i));
            chk("stream_in_ready", BW'(in_ready), BW'(1));
            chk("stream_bubble", BW'(bubble_cnt), BW'(1));
        end
        in_valid = 1'b0;
        cyc();
        chk("drain_valid", BW'(out_valid), BW'(0));

        send(8'h10);
        out_ready = 1'b0;
        send(8'h14);
        chk("stall_in_ready", BW'(in_ready), BW'(0));
        chk("stall_pc", BW'(out_pc), BW'(8'h10));
        apply(8'h18);
        cyc();
        chk("stall_hold_pc", BW'(out_pc), BW'(8'h10));
        chk("stall_hold_ready", BW'(in_ready), BW'(0));
        out_ready = 1'b1;
        send(8'h18);
        in_valid = 1'b0;
        chk("unstall_pc", BW'(out_pc), BW'(8'h18));
        cyc();

        out_ready = 1'b0;
        send(8'h20);
        send(8'h24);
        chk("preflush_ready", BW'(in_ready), BW'(0));
        apply(8'h28);
        in_valid = 1'b1;
        flush = 1'b1;
        exp_q.delete();
        cyc();
        flush = 1'b0;
        chk("flush_valid", BW'(out_valid), BW'(0));
        chk("flush_ctrl", BW'({out_wb, out_m, out_ex}), BW'(0));
        chk("flush_in_ready", BW'(in_ready), BW'(1));
        out_ready = 1'b1;
        send(8'h2C);
        in_valid = 1'b0;
        chk("postflush_pc", BW'(out_pc), BW'(8'h2C));
        chk("postflush_valid", BW'(out_valid), BW'(1));
        cyc();

        out_ready = 1'b0;
        send(8'h30);
        send(8'h34);
        in_valid = 1'b0;
        chk("full_in_ready", BW'(in_ready), BW'(0));
        rst_n = 1'b0;
        exp_q.delete();
        cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        chk("mrst_valid", BW'(out_valid), BW'(0));
        chk("mrst_in_ready", BW'(in_ready), BW'(1));
        chk("mrst_data", BW'({out_pc, out_instr, out_reg1, out_imm}), BW'(0));
        chk("mrst_bubble", BW'(bubble_cnt), BW'(0));

        for (int i = 1; i <= 20; i++) begin
            cyc();
            chk("sat_bubble", BW'(bubble_cnt), BW'((i > 15) ? 15 : i));
            chk("sat_valid", BW'(out_valid), BW'(0));
            $display("idle cycle %0d bubble_cnt=%0d", i, bubble_cnt);
        end

        chk("queue_empty", BW'(exp_q.size()), BW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
